// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit.
//   - RISC-V funct3 encodings for the supported load/store widths
//   - lsu_state_t: FSM state encoding, also exported as a debug output
//   - is_legal_access(): decides if an access may go to memory at all
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Legal: byte anywhere, half on even address, word on 4-byte boundary.
  // The unsigned variants (BU/HU) only exist for loads.
  function automatic logic is_legal_access(input logic       is_store,
                                           input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bus bundle of the load/store unit: EX request side, writeback response
// side and the data-memory side.
//   slave  : view of the load/store unit itself
//   master : view of the surroundings (core + memory)
//
// Handshake: EX presents a request with req_valid and holds every req_*
// field stable while stall=1. Towards memory, mem_req is the valid; the
// request and all mem_* fields stay stable until a cycle with mem_ready=1,
// in which the access completes (mem_rdata is sampled in that cycle for
// loads). resp_valid is a single-cycle pulse with no back-pressure.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              fault;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    input  mem_ready, mem_rdata,
    output stall, resp_valid, resp_rdata, fault,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
    output mem_ready, mem_rdata,
    input  stall, resp_valid, resp_rdata, fault,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/load_store_unit_load_align.sv
// load_align: combinational load-data formatter.
//   rdata_i  : raw 32-bit memory word
//   offset_i : byte offset of the access inside the word
//   funct3_i : load width / signedness
//   result_o : right-aligned, sign- or zero-extended load result
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    result_o = rdata_i;
    case (funct3_i)
      F3_B:    result_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   result_o = {24'd0, shifted[7:0]};
      F3_H:    result_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   result_o = {16'd0, shifted[15:0]};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: issues one EX load/store at a time to data memory and
// stalls the core until it completes.
//   clk, reset : core clock, synchronous active-high reset
//   bus        : request / response / memory signals (slave view)
//   state_o    : current FSM state, for debug and checkers
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  load_store_unit_if.slave   bus,
  output lsu_state_t         state_o
);

  if (DATA_W != 32) begin : g_data_w_check
    $error("load_store_unit: DATA_W must be 32");
  end

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic [31:0]       rdata_q;

  logic        legal;
  logic        accept;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] load_result;

  assign legal  = is_legal_access(bus.req_is_store, bus.req_funct3, bus.req_addr[1:0]);
  assign accept = (state_q == IDLE) && bus.req_valid && legal;

  // Store lanes: replicate the datum so any byte/half lane carries it;
  // the byte enables select the lane actually written.
  always_comb begin
    st_wdata = bus.req_wdata;
    st_be    = 4'b1111;
    if (bus.req_is_store) begin
      case (bus.req_funct3[1:0])
        2'b00: begin
          st_wdata = {4{bus.req_wdata[7:0]}};
          st_be    = 4'b0001 << bus.req_addr[1:0];
        end
        2'b01: begin
          st_wdata = {2{bus.req_wdata[15:0]}};
          st_be    = 4'b0011 << bus.req_addr[1:0];
        end
        default: begin
          st_wdata = bus.req_wdata;
          st_be    = 4'b1111;
        end
      endcase
    end
  end

  load_align u_load_align (
    .rdata_i  (bus.mem_rdata),
    .offset_i (off_q),
    .funct3_i (f3_q),
    .result_o (load_result)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (bus.mem_ready) state_d = DONE;
      DONE:    state_d = IDLE;  // req_valid still held by EX here is the finished instruction
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= 32'd0;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
        we_q    <= bus.req_is_store;
        be_q    <= st_be;
        wdata_q <= st_wdata;
        off_q   <= bus.req_addr[1:0];
        f3_q    <= bus.req_funct3;
      end
      if ((state_q == REQ) && bus.mem_ready && !we_q) begin
        rdata_q <= load_result;
      end
    end
  end

  // A request is abandoned on reset, so stall/fault are forced low then.
  assign bus.stall      = !reset && (accept || (state_q == REQ));
  assign bus.fault      = !reset && (state_q == IDLE) && bus.req_valid && !legal;
  assign bus.resp_valid = (state_q == DONE) && !we_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.mem_req    = (state_q == REQ);
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_be     = be_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: drives EX requests, plays the memory
// with a programmable number of wait cycles and scores load results
// through an expected queue.
module tb_load_store_unit;
  import mem_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  lsu_state_t state;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One access from request to DONE. The memory answers in the
  // (wait_cycles+1)-th mem_req cycle. Returns with the DUT in DONE and
  // req_valid still high, so a following call is back-to-back.
  task automatic do_access(input string       name,
                           input logic        is_store,
                           input logic [2:0]  f3,
                           input logic [31:0] addr,
                           input logic [31:0] wdata,
                           input logic [31:0] mem_word,
                           input int          wait_cycles,
                           input logic [31:0] exp_addr,
                           input logic [3:0]  exp_be,
                           input logic [31:0] exp_wdata,
                           input logic [31:0] exp_rdata);
    int stall_cnt = 0;
    int req_cnt   = 0;
    int resp_cnt  = 0;
    bit done      = 1'b0;
    @(posedge clk); #1;
    bus.req_valid    = 1'b1;
    bus.req_is_store = is_store;
    bus.req_funct3   = f3;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.mem_ready    = 1'b0;
    bus.mem_rdata    = 32'hFFFF_FFFF;
    if (!is_store) exp_q.push_back(exp_rdata);
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      check({name, " fault"}, 32'(bus.fault), 32'd0);
      if (bus.stall) stall_cnt++;
      if (bus.resp_valid) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          check({name, " unexpected resp"}, 32'd1, 32'd0);
        end else begin
          check({name, " resp_rdata"}, bus.resp_rdata, exp_q.pop_front());
        end
      end
      if (bus.mem_req) begin
        req_cnt++;
        check({name, " mem_addr"}, bus.mem_addr, exp_addr);
        check({name, " mem_be"}, 32'(bus.mem_be), 32'(exp_be));
        check({name, " mem_we"}, 32'(bus.mem_we), 32'(is_store));
        if (is_store) check({name, " mem_wdata"}, bus.mem_wdata, exp_wdata);
        bus.mem_ready = (req_cnt == wait_cycles + 1);
        bus.mem_rdata = (req_cnt == wait_cycles + 1) ? mem_word : 32'hFFFF_FFFF;
      end
      if (state == DONE) done = 1'b1;
    end
    bus.mem_ready = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s timeout waiting for DONE", name);
    end
    check({name, " stall cycles"}, 32'(stall_cnt), 32'(wait_cycles + 2));
    check({name, " mem_req cycles"}, 32'(req_cnt), 32'(wait_cycles + 1));
    check({name, " resp pulses"}, 32'(resp_cnt), is_store ? 32'd0 : 32'd1);
    if (!is_store) last_rdata = exp_rdata;
  endtask

  // Drop the request and confirm the unit is idle with resp_rdata held.
  task automatic go_idle(input string name);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check({name, " idle state"}, 32'(state), 32'(IDLE));
    check({name, " idle stall"}, 32'(bus.stall), 32'd0);
    check({name, " idle resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({name, " idle resp_rdata hold"}, bus.resp_rdata, last_rdata);
  endtask

  // Illegal access: faults immediately, never reaches memory.
  task automatic do_fault(input string name, input logic is_store,
                          input logic [2:0] f3, input logic [31:0] addr);
    @(posedge clk); #1;
    bus.req_valid    = 1'b1;
    bus.req_is_store = is_store;
    bus.req_funct3   = f3;
    bus.req_addr     = addr;
    bus.req_wdata    = 32'h5555_AAAA;
    @(negedge clk);
    check({name, " fault"}, 32'(bus.fault), 32'd1);
    check({name, " stall"}, 32'(bus.stall), 32'd0);
    check({name, " mem_req"}, 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    check({name, " still idle"}, 32'(state), 32'(IDLE));
    check({name, " mem_req later"}, 32'(bus.mem_req), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check({name, " fault clears"}, 32'(bus.fault), 32'd0);
    check({name, " mem_req after"}, 32'(bus.mem_req), 32'd0);
  endtask

  initial begin
    last_rdata       = 32'd0;
    reset            = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = F3_W;
    bus.req_addr     = 32'h0000_0000;
    bus.req_wdata    = 32'd0;
    bus.mem_ready    = 1'b0;
    bus.mem_rdata    = 32'd0;

    // Reset with a legal request present: must stay quiet.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset state", 32'(state), 32'(IDLE));
    check("reset stall", 32'(bus.stall), 32'd0);
    check("reset fault", 32'(bus.fault), 32'd0);
    check("reset mem_req", 32'(bus.mem_req), 32'd0);
    check("reset mem_we", 32'(bus.mem_we), 32'd0);
    check("reset mem_be", 32'(bus.mem_be), 32'd0);
    check("reset mem_addr", bus.mem_addr, 32'd0);
    check("reset mem_wdata", bus.mem_wdata, 32'd0);
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset resp_rdata", bus.resp_rdata, 32'd0);
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.req_valid = 1'b0;

    // Stores
    do_access("sw", 1'b1, F3_W, 32'h100, 32'hDEAD_BEEF, 32'h0, 0,
              32'h100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    go_idle("sw");
    do_access("sb", 1'b1, F3_B, 32'h103, 32'h0000_00A5, 32'h0, 0,
              32'h100, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    go_idle("sb");
    do_access("sh", 1'b1, F3_H, 32'h102, 32'h1234_BEEF, 32'h0, 1,
              32'h100, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    go_idle("sh");

    // Loads, back-to-back
    do_access("lb", 1'b0, F3_B, 32'h102, 32'h0, 32'h1280_3456, 0,
              32'h100, 4'b1111, 32'h0, 32'hFFFF_FF80);
    do_access("lbu", 1'b0, F3_BU, 32'h102, 32'h0, 32'h1280_3456, 0,
              32'h100, 4'b1111, 32'h0, 32'h0000_0080);
    do_access("lh", 1'b0, F3_H, 32'h102, 32'h0, 32'h1280_3456, 0,
              32'h100, 4'b1111, 32'h0, 32'h0000_1280);
    go_idle("lh");
    do_access("lh0", 1'b0, F3_H, 32'h100, 32'h0, 32'h0000_F00D, 0,
              32'h100, 4'b1111, 32'h0, 32'hFFFF_F00D);
    do_access("lhu0", 1'b0, F3_HU, 32'h100, 32'h0, 32'h0000_F00D, 0,
              32'h100, 4'b1111, 32'h0, 32'h0000_F00D);
    do_access("lb1", 1'b0, F3_B, 32'h101, 32'h0, 32'h0000_7F00, 2,
              32'h100, 4'b1111, 32'h0, 32'h0000_007F);
    go_idle("lb1");
    do_access("sw hold", 1'b1, F3_W, 32'h104, 32'h0102_0304, 32'h0, 0,
              32'h104, 4'b1111, 32'h0102_0304, 32'h0);
    go_idle("sw hold");

    // Illegal accesses
    do_fault("lh misaligned", 1'b0, F3_H, 32'h101);
    do_fault("load f3 011", 1'b0, 3'b011, 32'h100);
    do_fault("sw misaligned", 1'b1, F3_W, 32'h102);
    do_fault("store f3 100", 1'b1, F3_BU, 32'h100);

    // Wait states
    do_access("lw wait", 1'b0, F3_W, 32'h200, 32'h0, 32'h0BAD_F00D, 3,
              32'h200, 4'b1111, 32'h0, 32'h0BAD_F00D);
    go_idle("lw wait");

    // Reset while the memory is stalling in REQ
    @(posedge clk); #1;
    bus.req_valid    = 1'b1;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = F3_W;
    bus.req_addr     = 32'h300;
    bus.mem_ready    = 1'b0;
    @(posedge clk); #1;
    check("rst-in-req entered REQ", 32'(state), 32'(REQ));
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst-in-req stall during reset", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst-in-req mem_req", 32'(bus.mem_req), 32'd0);
    check("rst-in-req stall", 32'(bus.stall), 32'd0);
    check("rst-in-req state", 32'(state), 32'(IDLE));
    check("rst-in-req resp_valid", 32'(bus.resp_valid), 32'd0);
    last_rdata = 32'd0;
    do_access("lw after rst", 1'b0, F3_W, 32'h300, 32'h0, 32'hCAFE_BABE, 1,
              32'h300, 4'b1111, 32'h0, 32'hCAFE_BABE);
    go_idle("lw after rst");

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
